// File: rtl/ws_pkg.sv
// ws_pkg: state encoding and constants shared by the weight-stationary column sequencer.
package ws_pkg;

    localparam int DATA_TYPE_DEFAULT = 16;
    localparam logic [15:0] BFP16_ZERO = 16'h0000;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } ws_seq_state_t;

endpackage

// File: rtl/ws_valid_tracker.sv
// ws_valid_tracker: DEPTH-stage serial shift register marking which column slots carry a
// real vector; any_o reports whether any vector is still in flight.
module ws_valid_tracker #(
    parameter int DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    output logic out_o,
    output logic any_o
);

    logic [DEPTH-1:0] sr_q;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) sr_q <= '0;
                else       sr_q <= push_i;
            end
        end else begin : g_shift
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) sr_q <= '0;
                else       sr_q <= {sr_q[DEPTH-2:0], push_i};
            end
        end
    endgenerate

    assign out_o = sr_q[DEPTH-1];
    assign any_o = |sr_q;

endmodule

// File: rtl/ws_col_seq.sv
// ws_col_seq: preloads one weight per PE row, then streams ifmap vectors down the column.
// Defining WS_COL_SEQ_STALL_CNT_EN adds stall_cnt_o (STREAM cycles starved of x_valid_i).
//   state  | meaning
//   IDLE   | waiting for start_i
//   LOAD   | accepting one weight per row, top row first
//   STREAM | accepting ifmap vectors with a zero psum at the top
//   DRAIN  | waiting for in-flight vectors to leave the column
//   DONE   | one-cycle done_o pulse
module ws_col_seq
    import ws_pkg::*;
#(
    parameter int ROWS      = 4,
    parameter int DATA_TYPE = DATA_TYPE_DEFAULT,
    parameter int PE_LAT    = 1,
    parameter int CNT_W     = 11
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [CNT_W-1:0]     n_vec_i,
    output logic                 busy_o,
    output logic                 done_o,
    input  logic                 w_valid_i,
    output logic                 w_ready_o,
    input  logic [DATA_TYPE-1:0] w_data_i,
    input  logic                 x_valid_i,
    output logic                 x_ready_o,
    input  logic [DATA_TYPE-1:0] x_data_i,
    output logic [ROWS-1:0]      pe_ctrl_o,
    output logic [DATA_TYPE-1:0] pe_in_o,
    output logic [DATA_TYPE-1:0] pe_ifmap_o,
    output logic                 out_valid_o
`ifdef WS_COL_SEQ_STALL_CNT_EN
    ,
    output logic [31:0]          stall_cnt_o
`endif
);

    localparam int DEPTH = ROWS * PE_LAT;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    ws_seq_state_t        state_q, state_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ROWS-1:0]      pe_ctrl_q, pe_ctrl_d;
    logic [DATA_TYPE-1:0] pe_in_q, pe_in_d;
    logic [DATA_TYPE-1:0] pe_ifmap_q, pe_ifmap_d;
    logic                 out_valid_q;
    logic                 x_hs;
    logic                 trk_out;
    logic                 trk_any;

    assign x_hs = (state_q == STREAM) && x_valid_i;

    ws_valid_tracker #(
        .DEPTH(DEPTH)
    ) u_tracker (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push_i(x_hs),
        .out_o (trk_out),
        .any_o (trk_any)
    );

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        cnt_d      = cnt_q;
        pe_ctrl_d  = '1;
        pe_in_d    = pe_in_q;
        pe_ifmap_d = pe_ifmap_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    cnt_d   = n_vec_i;
                    row_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (w_valid_i) begin
                    pe_in_d   = w_data_i;
                    pe_ctrl_d = ~(ROWS'(1) << row_q);
                    if (row_q == ROW_W'(ROWS - 1)) begin
                        row_d   = '0;
                        state_d = (cnt_q == '0) ? DONE : STREAM;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end
            STREAM: begin
                if (x_valid_i) begin
                    pe_ifmap_d = x_data_i;
                    pe_in_d    = DATA_TYPE'(BFP16_ZERO);
                    cnt_d      = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!trk_any) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            row_q       <= '0;
            cnt_q       <= '0;
            pe_ctrl_q   <= '1;
            pe_in_q     <= '0;
            pe_ifmap_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            pe_ctrl_q   <= pe_ctrl_d;
            pe_in_q     <= pe_in_d;
            pe_ifmap_q  <= pe_ifmap_d;
            // Extra stage aligns out_valid_o with the bottom psum, one cycle after the last tracker slot.
            out_valid_q <= trk_out;
        end
    end

    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);
    assign w_ready_o   = (state_q == LOAD);
    assign x_ready_o   = (state_q == STREAM);
    assign pe_ctrl_o   = pe_ctrl_q;
    assign pe_in_o     = pe_in_q;
    assign pe_ifmap_o  = pe_ifmap_q;
    assign out_valid_o = out_valid_q;

`ifdef WS_COL_SEQ_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_q <= '0;
        end else if ((state_q == IDLE) && start_i) begin
            stall_q <= '0;
        end else if ((state_q == STREAM) && !x_valid_i && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_ws_col_seq.sv
// tb_ws_col_seq: directed and randomized tiles checked against a transaction-level model.
module tb_ws_col_seq;

    localparam int ROWS   = 4;
    localparam int PE_LAT = 1;
    localparam int CNT_W  = 11;
    localparam int DW     = 16;
    localparam int D      = ROWS * PE_LAT;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] n_vec = '0;
    logic             busy, done;
    logic             w_valid = 1'b0, w_ready;
    logic [DW-1:0]    w_data = '0;
    logic             x_valid = 1'b0, x_ready;
    logic [DW-1:0]    x_data = '0;
    logic [ROWS-1:0]  pe_ctrl;
    logic [DW-1:0]    pe_in, pe_ifmap;
    logic             out_valid;
`ifdef WS_COL_SEQ_STALL_CNT_EN
    logic [31:0]      stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ws_col_seq #(
        .ROWS(ROWS), .DATA_TYPE(DW), .PE_LAT(PE_LAT), .CNT_W(CNT_W)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .n_vec_i    (n_vec),
        .busy_o     (busy),
        .done_o     (done),
        .w_valid_i  (w_valid),
        .w_ready_o  (w_ready),
        .w_data_i   (w_data),
        .x_valid_i  (x_valid),
        .x_ready_o  (x_ready),
        .x_data_i   (x_data),
        .pe_ctrl_o  (pe_ctrl),
        .pe_in_o    (pe_in),
        .pe_ifmap_o (pe_ifmap),
        .out_valid_o(out_valid)
`ifdef WS_COL_SEQ_STALL_CNT_EN
        ,
        .stall_cnt_o(stall_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Transaction-level model: phase 0 idle, 1 weights, 2 vectors, 3 wait, 4 end pulse.
    // Results are scheduled by absolute cycle number instead of being shifted.
    int              cyc = 0;
    int              phase = 0;
    int              row = 0;
    int              nv = 0;
    int              done_at = 0;
    bit              ov_at[int];
    logic            e_busy = 0, e_done = 0, e_wr = 0, e_xr = 0, e_ov = 0;
    logic [ROWS-1:0] e_ctrl = '1;
    logic [DW-1:0]   e_in = '0, e_ifmap = '0;
    logic [31:0]     e_stall = '0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                phase = 0;
                ov_at.delete();
                e_ctrl = '1; e_in = '0; e_ifmap = '0; e_ov = 0; e_stall = '0;
            end else begin
                cyc++;
                e_ctrl = '1;
                case (phase)
                    0: if (start) begin
                        nv = int'(n_vec); row = 0; phase = 1; e_stall = '0;
                    end
                    1: if (w_valid) begin
                        e_in = w_data;
                        e_ctrl[row] = 1'b0;
                        row++;
                        if (row == ROWS) phase = (nv == 0) ? 4 : 2;
                    end
                    2: begin
                        if (!x_valid && e_stall != 32'hFFFF_FFFF) e_stall++;
                        if (x_valid) begin
                            e_ifmap = x_data;
                            e_in = '0;
                            ov_at[cyc + D] = 1'b1;
                            nv--;
                            if (nv == 0) begin
                                phase = 3;
                                done_at = cyc + D + 1;
                            end
                        end
                    end
                    3: if (cyc >= done_at) phase = 4;
                    default: phase = 0;
                endcase
                e_ov = ov_at.exists(cyc);
                if (e_ov) ov_at.delete(cyc);
            end
            e_busy = (phase != 0);
            e_done = (phase == 4);
            e_wr   = (phase == 1);
            e_xr   = (phase == 2);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("cmp_busy", busy, e_busy);
            chk("cmp_done", done, e_done);
            chk("cmp_w_ready", w_ready, e_wr);
            chk("cmp_x_ready", x_ready, e_xr);
            chk("cmp_pe_ctrl", pe_ctrl, e_ctrl);
            chk("cmp_pe_in", pe_in, e_in);
            chk("cmp_pe_ifmap", pe_ifmap, e_ifmap);
            chk("cmp_out_valid", out_valid, e_ov);
`ifdef WS_COL_SEQ_STALL_CNT_EN
            chk("cmp_stall_cnt", stall_cnt, e_stall);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_weights();
        for (int i = 0; i < ROWS; i++) begin
            w_valid = 1'b1;
            w_data  = DW'($urandom);
            tick();
        end
        w_valid = 1'b0;
    endtask

    task automatic run_tile(input int n, input bit cont, output bit found);
        int budget;
        found  = 1'b0;
        budget = cont ? (n * 4 + 200) : (n * 20 + 200);
        start  = 1'b1;
        n_vec  = CNT_W'(n);
        tick();
        start = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            w_valid = cont | ($urandom_range(0, 2) != 0);
            x_valid = cont | ($urandom_range(0, 2) != 0);
            w_data  = DW'($urandom);
            x_data  = DW'($urandom);
            start   = ($urandom_range(0, 5) == 0);
            n_vec   = CNT_W'($urandom);
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                start = 1'b0; w_valid = 1'b0; x_valid = 1'b0;
            end
            tick();
        end
        start = 1'b0; w_valid = 1'b0; x_valid = 1'b0;
    endtask

    logic [DW-1:0]   W_LIT [4] = '{16'h4040, 16'h4100, 16'h4480, 16'h3FA0};
    logic [DW-1:0]   X_LIT [4] = '{16'h3F80, 16'h449B, 16'h4600, 16'h4020};
    logic [ROWS-1:0] C_LIT [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    initial begin
        logic [15:0] ov_seen;
        logic [6:0]  pat;
        logic        busy_hist [64];
        logic        wr_hist [64];
        int          done_cnt, done_idx, ov_cnt, d1, d2;
        bit          xr_seen, found;

        // Reset values
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_pe_ctrl", pe_ctrl, 4'hF);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_pe_in", pe_in, 16'h0000);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Weight load followed by a continuous stream of four vectors
        start = 1'b1; n_vec = 11'd4; w_valid = 1'b1; w_data = W_LIT[0];
        x_valid = 1'b1; x_data = 16'hDEAD;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_data = W_LIT[i];
            tick();
            @(negedge clk);
            chk("load_pe_ctrl", pe_ctrl, C_LIT[i]);
            chk("load_pe_in", pe_in, W_LIT[i]);
            chk("load_busy", busy, 1'b1);
        end
        w_valid = 1'b0;
        ov_seen = '0; done_cnt = 0; done_idx = -1;
        for (int j = 0; j < 4; j++) begin
            x_data = X_LIT[j];
            tick();
            @(negedge clk);
            chk("stream_pe_ifmap", pe_ifmap, X_LIT[j]);
            chk("stream_pe_in", pe_in, 16'h0000);
            chk("stream_pe_ctrl", pe_ctrl, 4'hF);
            ov_seen[j] = out_valid;
        end
        x_valid = 1'b0;
        for (int k = 4; k < 16; k++) begin
            @(negedge clk);
            ov_seen[k] = out_valid;
            if (done) begin done_cnt++; done_idx = k; end
        end
        chk("cont_out_valid_pattern", ov_seen, 16'h00F0);
        chk("cont_done_count", done_cnt, 1);
        chk("cont_done_cycle", done_idx, 8);

        // Stalled stream: accepted pattern 1,0,0,1,1,0,1
        tick();
        start = 1'b1; n_vec = 11'd4;
        tick();
        start = 1'b0;
        load_weights();
        pat = 7'b1011001;
        ov_seen = '0; done_cnt = 0; done_idx = -1;
        for (int k = 0; k < 7; k++) begin
            x_valid = pat[k];
            x_data  = DW'($urandom);
            tick();
            @(negedge clk);
            ov_seen[k] = out_valid;
        end
        x_valid = 1'b0;
        for (int k = 7; k < 16; k++) begin
            @(negedge clk);
            ov_seen[k] = out_valid;
            if (done) begin done_cnt++; done_idx = k; end
        end
        chk("stall_out_valid_pattern", ov_seen, 16'h0590);
        chk("stall_done_cycle", done_idx, 11);
`ifdef WS_COL_SEQ_STALL_CNT_EN
        chk("stall_cnt_value", stall_cnt, 32'd3);
`endif

        // Zero vectors with spurious x_valid
        tick();
        start = 1'b1; n_vec = 11'd0; w_valid = 1'b1; x_valid = 1'b1;
        tick();
        start = 1'b0;
        done_cnt = 0; done_idx = -1; xr_seen = 1'b0;
        for (int m = 0; m < 10; m++) begin
            @(negedge clk);
            if (x_ready) xr_seen = 1'b1;
            if (done) begin done_cnt++; done_idx = m; end
            w_data = DW'($urandom);
        end
        w_valid = 1'b0; x_valid = 1'b0;
        chk("zero_x_ready_seen", xr_seen, 1'b0);
        chk("zero_done_cycle", done_idx, ROWS);
        chk("zero_done_count", done_cnt, 1);

        // Reset after two of four vectors
        tick();
        start = 1'b1; n_vec = 11'd4;
        tick();
        start = 1'b0;
        load_weights();
        x_valid = 1'b1;
        repeat (2) begin
            x_data = DW'($urandom);
            tick();
        end
        x_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_x_ready", x_ready, 1'b0);
        chk("midrst_pe_ctrl", pe_ctrl, 4'hF);
        chk("midrst_pe_ifmap", pe_ifmap, 16'h0000);
        chk("midrst_pe_in", pe_in, 16'h0000);
        chk("midrst_out_valid", out_valid, 1'b0);
        tick();
        rst = 1'b0;
        ov_cnt = 0; done_cnt = 0;
        for (int m = 0; m < 15; m++) begin
            @(negedge clk);
            if (out_valid) ov_cnt++;
            if (done) done_cnt++;
        end
        chk("midrst_late_out_valid", ov_cnt, 0);
        chk("midrst_late_done", done_cnt, 0);
        tick();
        run_tile(2, 1'b0, found);
        chk("midrst_new_tile_done", found, 1'b1);

        // Back-to-back tiles with start held high
        start = 1'b1; n_vec = 11'd3; w_valid = 1'b1; x_valid = 1'b1;
        tick();
        d1 = -1; d2 = -1;
        for (int m = 0; m < 60; m++) begin
            @(negedge clk);
            busy_hist[m] = busy;
            wr_hist[m]   = w_ready;
            if (done) begin
                if (d1 < 0) d1 = m;
                else if (d2 < 0) begin d2 = m; start = 1'b0; end
            end
            w_data = DW'($urandom);
            x_data = DW'($urandom);
        end
        start = 1'b0; w_valid = 1'b0; x_valid = 1'b0;
        chk("b2b_first_done", d1, 12);
        chk("b2b_tile_period", d2 - d1, 14);
        if (d1 < 0 || d1 > 60) d1 = 0;
        chk("b2b_idle_after_done", busy_hist[d1 + 1], 1'b0);
        chk("b2b_second_load", wr_hist[d1 + 2], 1'b1);
        tick();

        // Randomized tiles
        for (int t = 0; t < 12; t++) begin
            run_tile($urandom_range(0, 6), 1'b0, found);
            chk("rand_tile_done", found, 1'b1);
        end

        // Largest vector count: must not wrap
        run_tile((1 << CNT_W) - 1, 1'b1, found);
        chk("max_count_done", found, 1'b1);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
